// File: rtl/calculus_grad_unit_if.sv
// Handshake bundle between a lane's gradient unit and its neighbours.
// The master side feeds beats in and accepts results; the slave side is the unit.
interface calculus_grad_unit_if #(
    parameter int FUNCTION_BITS = 4,
    parameter int BIT_WIDTH     = 32
);
    logic                     in_valid;
    logic                     in_ready;
    logic [FUNCTION_BITS-1:0] fn;
    logic [BIT_WIDTH-1:0]     data_in0;
    logic [BIT_WIDTH-1:0]     data_in1;
    logic [7:0]               dest_integer_bits;
    logic [7:0]               src2_integer_bits;
    logic                     out_valid;
    logic                     out_ready;
    logic [BIT_WIDTH-1:0]     data_out;
    logic                     out_illegal;

    modport master (
        output in_valid, fn, data_in0, data_in1, dest_integer_bits, src2_integer_bits, out_ready,
        input  in_ready, out_valid, data_out, out_illegal
    );

    modport slave (
        input  in_valid, fn, data_in0, data_in1, dest_integer_bits, src2_integer_bits, out_ready,
        output in_ready, out_valid, data_out, out_illegal
    );
endinterface

// File: rtl/calculus_grad_unit.sv
// ReLU'/ABS'/SIGN' backward gradient with fixed-point realignment; CALC_GRAD_SAT_EN enables saturation.
// Latency 2 cycles from acceptance, 1 beat/cycle throughput.
// A stalled output holds both stages; in_ready drops only when both stages are full.
module calculus_grad_unit #(
    parameter int FUNCTION_BITS = 4,
    parameter int BIT_WIDTH     = 32
) (
    input logic                 clk,
    input logic                 reset,
    calculus_grad_unit_if.slave bus
);
    localparam logic [FUNCTION_BITS-1:0] FN_RELU = FUNCTION_BITS'(0);
    localparam logic [FUNCTION_BITS-1:0] FN_ABS  = FUNCTION_BITS'(2);
    localparam logic [FUNCTION_BITS-1:0] FN_SIGN = FUNCTION_BITS'(3);
    localparam logic [8:0]               W9      = 9'(BIT_WIDTH);
`ifdef CALC_GRAD_SAT_EN
    localparam logic [BIT_WIDTH-1:0] MAX_V = {1'b0, {(BIT_WIDTH-1){1'b1}}};
    localparam logic [BIT_WIDTH-1:0] MIN_V = {1'b1, {(BIT_WIDTH-1){1'b0}}};
`endif

    logic                     s1_valid;
    logic [FUNCTION_BITS-1:0] s1_fn;
    logic                     s1_x_neg;
    logic [BIT_WIDTH-1:0]     s1_g;
    logic signed [8:0]        s1_sh;

    logic                     s2_valid;
    logic [BIT_WIDTH-1:0]     s2_data;
    logic                     s2_illegal;

    logic adv1, adv2;
    assign adv2         = ~s2_valid | bus.out_ready;
    assign adv1         = ~s1_valid | adv2;
    assign bus.in_ready = adv1;

    assign bus.out_valid   = s2_valid;
    assign bus.data_out    = s2_data;
    assign bus.out_illegal = s2_illegal;

    // Only the sign of x matters to every supported derivative.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_fn    <= '0;
            s1_x_neg <= 1'b0;
            s1_g     <= '0;
            s1_sh    <= '0;
        end else if (adv1) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_fn    <= bus.fn;
                s1_x_neg <= bus.data_in0[BIT_WIDTH-1];
                s1_g     <= bus.data_in1;
                s1_sh    <= $signed({1'b0, bus.dest_integer_bits}) - $signed({1'b0, bus.src2_integer_bits});
            end
        end
    end

    logic [BIT_WIDTH-1:0] neg_g, p, res;
    logic                 illegal;
    logic [8:0]           sh_pos, sh_neg, amt;
`ifdef CALC_GRAD_SAT_EN
    logic [2*BIT_WIDTH-1:0] ext;
    logic                   ovf;
`endif

    assign sh_pos = s1_sh;
    assign sh_neg = -s1_sh;

    always_comb begin
        neg_g   = -s1_g;
`ifdef CALC_GRAD_SAT_EN
        if (s1_g == MIN_V) neg_g = MAX_V;
`endif
        p       = '0;
        illegal = 1'b0;
        case (s1_fn)
            FN_RELU: p = s1_x_neg ? '0 : s1_g;
            FN_ABS:  p = s1_x_neg ? neg_g : s1_g;
            FN_SIGN: p = '0;
            default: illegal = 1'b1;
        endcase

        res = p;
        amt = '0;
`ifdef CALC_GRAD_SAT_EN
        ext = '0;
        ovf = 1'b0;
`endif
        if (!s1_sh[8] && (s1_sh != 9'sd0)) begin
            // Shifting past the width leaves only copies of the sign bit.
            amt = (sh_pos >= W9) ? W9 - 9'd1 : sh_pos;
            res = $signed(p) >>> amt;
        end else if (s1_sh[8]) begin
            amt = (sh_neg >= W9) ? W9 : sh_neg;
`ifdef CALC_GRAD_SAT_EN
            ext = {{BIT_WIDTH{p[BIT_WIDTH-1]}}, p} << amt;
            ovf = ext[2*BIT_WIDTH-1:BIT_WIDTH-1] != {(BIT_WIDTH+1){p[BIT_WIDTH-1]}};
            res = ovf ? (p[BIT_WIDTH-1] ? MIN_V : MAX_V) : ext[BIT_WIDTH-1:0];
`else
            res = p << amt;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid   <= 1'b0;
            s2_data    <= '0;
            s2_illegal <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data    <= res;
                s2_illegal <= illegal;
            end
        end
    end
endmodule

// File: tb/tb_calculus_grad_unit.sv
// Scoreboarded random and directed bench for the backward gradient unit.
module tb_calculus_grad_unit;
    localparam int W = 32;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;
`ifdef CALC_GRAD_SAT_EN
    localparam bit SAT_ON = 1'b1;
`else
    localparam bit SAT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    calculus_grad_unit_if #(.FUNCTION_BITS(4), .BIT_WIDTH(W)) bus ();
    calculus_grad_unit #(.FUNCTION_BITS(4), .BIT_WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] d;
        logic         ill;
        int           acc;
        bit           lat;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   occ = 0;
    int   mode = 1;
    bit   lat_en = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference derivative and realignment in plain integer arithmetic.
    function automatic logic [W:0] model(input logic [3:0] f, input logic [W-1:0] x, g,
                                         input logic [7:0] d, s);
        longint p, big;
        int     sh;
        bit     ovf, neg;
        logic [W-1:0] r;
        ovf = 1'b0;
        if (!(f == 4'd0 || f == 4'd2 || f == 4'd3)) return {1'b1, {W{1'b0}}};
        if (f == 4'd3 || (f == 4'd0 && $signed(x) < 0)) p = 0;
        else if ($signed(x) >= 0) p = longint'($signed(g));
        else begin
            p = -longint'($signed(g));
            if (p > MAXV) p = SAT_ON ? MAXV : MINV;
        end
        neg = p < 0;
        sh = int'(d) - int'(s);
        if (sh > 0) p = p >>> ((sh > 40) ? 40 : sh);
        else if (sh < 0 && p != 0) begin
            if (-sh >= W) begin
                ovf = 1'b1;
                p = 0;
            end else begin
                big = p <<< (-sh);
                ovf = (big > MAXV) || (big < MINV);
                p = longint'($signed(big[W-1:0]));
            end
        end
        if (ovf && SAT_ON) p = neg ? MINV : MAXV;
        r = p[W-1:0];
        return {1'b0, r};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: in_ready rule from occupancy, then pop and compare on each output handshake.
    always @(negedge clk) begin
        exp_t e;
        bit   ih, oh;
        if (!reset) occ = 0;
        else begin
            chk("in_ready", 64'(bus.in_ready), 64'(bus.out_ready || (occ < 2)));
            ih = bus.in_valid && bus.in_ready;
            oh = bus.out_valid && bus.out_ready;
            if (oh) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_out: got data %0h with no expected beat", bus.data_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("data_out", 64'(bus.data_out), 64'(e.d));
                    chk("out_illegal", 64'(bus.out_illegal), 64'(e.ill));
                    if (e.lat) chk("latency", 64'(cyc - e.acc), 64'd2);
                end
            end
            occ = occ + int'(ih) - int'(oh);
        end
    end

    task automatic send(input logic [3:0] f, input logic [W-1:0] x, g, input logic [7:0] d, s);
        logic [W:0] m;
        int n;
        n = 0;
        m = model(f, x, g, d, s);
        bus.fn = f;
        bus.data_in0 = x;
        bus.data_in1 = g;
        bus.dest_integer_bits = d;
        bus.src2_integer_bits = s;
        bus.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back('{m[W-1:0], m[W], cyc, lat_en});
                break;
            end
            if (++n > 200) begin
                total++;
                bad++;
                $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d beats never came out", exp_q.size());
        end
        #1;
    endtask

    initial begin
        logic [3:0]   f;
        logic [W-1:0] x, g;
        logic [7:0]   d, s;
        bus.in_valid = 1'b0;
        bus.fn = '0;
        bus.data_in0 = '0;
        bus.data_in1 = '0;
        bus.dest_integer_bits = '0;
        bus.src2_integer_bits = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_data_out", 64'(bus.data_out), 64'd0);
        chk("rst_out_illegal", 64'(bus.out_illegal), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Directed beats, out_ready held high so every beat must take exactly 2 cycles.
        send(4'd0, 32'd5, 32'h0001_0000, 8'd15, 8'd15);
        drain();
        send(4'd0, -32'sd3, 32'h0000_0400, 8'd15, 8'd15);
        send(4'd2, -32'sd3, 32'h0000_0400, 8'd15, 8'd15);
        send(4'd2, 32'd0, 32'd7, 8'd15, 8'd15);
        send(4'd3, 32'd9, 32'd7, 8'd15, 8'd15);
        send(4'd5, 32'd9, 32'd7, 8'd15, 8'd15);
        send(4'd0, 32'd1, 32'h4000_0000, 8'd15, 8'd16);
        send(4'd0, 32'd1, -32'sd64, 8'd20, 8'd15);
        send(4'd2, -32'sd1, 32'h8000_0000, 8'd10, 8'd10);
        send(4'd2, 32'd1, 32'h8000_0000, 8'd200, 8'd0);
        send(4'd0, 32'd1, 32'h0000_0003, 8'd0, 8'd200);
        send(4'd2, -32'sd8, 32'h0000_0003, 8'd0, 8'd29);
        drain();

        // Eight back-to-back beats with a three-cycle output stall in the middle.
        lat_en = 1'b0;
        fork
            begin
                repeat (3) @(posedge clk);
                #1;
                mode = 0;
                repeat (3) @(posedge clk);
                #1;
                mode = 1;
            end
            for (int i = 0; i < 8; i++) send(4'd0, 32'd1, 32'(i * 17 + 1), 8'd8, 8'd8);
        join
        drain();

        // Reset with two beats held in the pipe; the next beat must see a clean 2-cycle latency.
        mode = 0;
        send(4'd0, 32'd1, 32'h1234_5678, 8'd8, 8'd8);
        send(4'd2, -32'sd1, 32'h0000_0055, 8'd8, 8'd8);
        reset = 1'b0;
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_data_out", 64'(bus.data_out), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        mode = 1;
        lat_en = 1'b1;
        send(4'd2, -32'sd5, 32'h0000_0100, 8'd12, 8'd10);
        drain();

        // Randomized traffic with random backpressure and idle gaps.
        lat_en = 1'b0;
        mode = 2;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0:       f = 4'd0;
                1:       f = 4'd2;
                2:       f = 4'd3;
                default: f = 4'($urandom_range(0, 15));
            endcase
            x = $urandom();
            g = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom();
            if ($urandom_range(0, 1) == 0) begin
                d = 8'($urandom_range(0, 40));
                s = 8'($urandom_range(0, 40));
            end else begin
                d = 8'($urandom_range(0, 255));
                s = 8'($urandom_range(0, 255));
            end
            send(f, x, g, d, s);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        mode = 1;
        drain();
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
